// File: rtl/cpu_boot_sequencer.sv
`timescale 1ns/1ps
// Purpose  : boot sequencer for the 8-bit CPU: loads a program into imem, holds the
//            core in reset, releases it, watches for halt / watchdog / PC overrun.
// Latency  : imem write strobe 1 cycle after each byte handshake; cpu_rst changes on the state edge.
// Backpress: s_ready is high for the whole LOAD state, so every s_valid cycle in LOAD is taken.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start, abort        start a load (IDLE/DONE/ERR only); abort returns to IDLE from anywhere
//   load_len            program length in bytes (1..2**ADDR_W), sampled on start
//   s_valid/s_ready/s_data   program byte stream
//   imem_we/imem_addr/imem_wdata  registered instruction-memory write port
//   cpu_rst             registered reset to the core, low only in RUN
//   cpu_pc, cpu_instr   observed core program counter and fetched instruction
//   busy, done, err_code, words_loaded   status
module cpu_boot_sequencer #(
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 8,
    parameter int          SETTLE_CYC = 2,
    parameter int          WDOG_W     = 16,
    parameter int          RUN_LIMIT  = 1000,
    parameter logic [3:0]  HALT_OP    = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic [DATA_W-1:0] cpu_instr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE, S_ERR
    } state_t;

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    // Counter is one bit wider than the address so a full 2**ADDR_W load never wraps.
    localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic [SET_W-1:0]  SET_ONE   = SET_W'(1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(RUN_LIMIT - 1);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

    state_t              state, state_nxt;
    logic [ADDR_W:0]     cnt, cnt_nxt;
    logic [ADDR_W:0]     len, len_nxt;
    logic [SET_W-1:0]    settle_cnt, settle_nxt;
    logic [WDOG_W-1:0]   wdog, wdog_nxt;
    logic [1:0]          err_nxt;
    logic                we_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;

    logic halt_hit;
    logic pc_over;
    logic unused_instr_low;

    assign halt_hit         = (cpu_instr[DATA_W-1 -: 4] == HALT_OP);
    assign pc_over          = ({1'b0, cpu_pc} >= len);
    assign unused_instr_low = ^cpu_instr[DATA_W-5:0];

    assign s_ready      = (state == S_LOAD);
    assign busy         = (state == S_LOAD) || (state == S_SETTLE) || (state == S_RUN);
    assign done         = (state == S_DONE);
    assign words_loaded = cnt;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        len_nxt    = len;
        settle_nxt = settle_cnt;
        wdog_nxt   = wdog;
        err_nxt    = err_code;
        we_nxt     = 1'b0;
        addr_nxt   = imem_addr;
        wdata_nxt  = imem_wdata;

        if (abort) begin
            // A byte handshaken in this same cycle is dropped: we_nxt stays 0.
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            err_nxt   = 2'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        if ((load_len == '0) || (load_len > CAPACITY)) begin
                            state_nxt = S_ERR;
                            err_nxt   = 2'd1;
                        end else begin
                            state_nxt = S_LOAD;
                            len_nxt   = load_len;
                            cnt_nxt   = '0;
                            err_nxt   = 2'd0;
                        end
                    end
                end
                S_LOAD: begin
                    if (s_valid) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = cnt[ADDR_W-1:0];
                        wdata_nxt = s_data;
                        cnt_nxt   = cnt + CNT_ONE;
                        if ((cnt + CNT_ONE) == len) begin
                            state_nxt  = S_SETTLE;
                            settle_nxt = '0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        state_nxt = S_RUN;
                        wdog_nxt  = '0;
                    end else begin
                        settle_nxt = settle_cnt + SET_ONE;
                    end
                end
                S_RUN: begin
                    if (halt_hit) begin
                        state_nxt = S_DONE;
                    end else if (wdog == WDOG_LAST) begin
                        state_nxt = S_ERR;
                        err_nxt   = 2'd2;
                    end else if (pc_over) begin
                        state_nxt = S_ERR;
                        err_nxt   = 2'd3;
                    end else begin
                        wdog_nxt = wdog + WDOG_ONE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len        <= '0;
            settle_cnt <= '0;
            wdog       <= '0;
            err_code   <= 2'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            len        <= len_nxt;
            settle_cnt <= settle_nxt;
            wdog       <= wdog_nxt;
            err_code   <= err_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= addr_nxt;
            imem_wdata <= wdata_nxt;
            // Core runs only while the FSM sits in RUN.
            cpu_rst    <= (state_nxt != S_RUN);
        end
    end

endmodule

// File: tb/tb_cpu_boot_sequencer.sv
`timescale 1ns/1ps
// Bench for cpu_boot_sequencer: directed load/run scenarios, a cycle model built from
// the phase rules (bytes remaining, settle cycles left, run cycles elapsed), checked
// every cycle, plus literal expectations after each scenario.
module tb_cpu_boot_sequencer;

    localparam int RUN_LIMIT  = 1000;
    localparam int SETTLE_CYC = 2;
    localparam int M_IDLE = 0, M_LOAD = 1, M_SETTLE = 2, M_RUN = 3, M_DONE = 4, M_ERR = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] load_len = '0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_rst;
    logic [7:0] cpu_pc = '0;
    logic [7:0] cpu_instr = '0;
    logic       busy;
    logic       done;
    logic [1:0] err_code;
    logic [8:0] words_loaded;

    always #5 clk = ~clk;

    cpu_boot_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .load_len(load_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
        .busy(busy), .done(done), .err_code(err_code), .words_loaded(words_loaded)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_strobe = 0;
    int n_run = 0;
    int n_settle = 0;
    bit chk_on = 1'b0;
    int q_addr[$];
    logic [7:0] mem [0:255];

    // Simple CPU stand-in: either steps through the loaded program or holds a fixed pc/instr.
    bit         cpu_step = 1'b0;
    logic [7:0] hold_pc = '0;
    logic [7:0] hold_instr = '0;
    logic       prev_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mode = M_IDLE, m_len = 0, m_words = 0, m_err = 0;
    int m_settle_left = 0, m_run_cycles = 0;
    int m_we = 0, m_addr = 0, m_wdata = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE; m_len = 0; m_words = 0; m_err = 0;
            m_settle_left = 0; m_run_cycles = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        end else begin
            m_we = 0;
            if (abort) begin
                m_mode = M_IDLE; m_words = 0; m_err = 0;
            end else if (m_mode == M_IDLE || m_mode == M_DONE || m_mode == M_ERR) begin
                if (start) begin
                    if (load_len == 0 || int'(load_len) > 256) begin
                        m_mode = M_ERR; m_err = 1;
                    end else begin
                        m_mode = M_LOAD; m_len = int'(load_len); m_words = 0; m_err = 0;
                    end
                end
            end else if (m_mode == M_LOAD) begin
                if (s_valid) begin
                    m_we = 1; m_addr = m_words; m_wdata = int'(s_data);
                    m_words++;
                    if (m_words == m_len) begin
                        m_mode = M_SETTLE; m_settle_left = SETTLE_CYC;
                    end
                end
            end else if (m_mode == M_SETTLE) begin
                m_settle_left--;
                if (m_settle_left == 0) begin
                    m_mode = M_RUN; m_run_cycles = 0;
                end
            end else if (m_mode == M_RUN) begin
                m_run_cycles++;
                if (cpu_instr[7:4] == 4'hF)         m_mode = M_DONE;
                else if (m_run_cycles == RUN_LIMIT) begin m_mode = M_ERR; m_err = 2; end
                else if (int'(cpu_pc) >= m_len)     begin m_mode = M_ERR; m_err = 3; end
            end
        end
    end

    // ---------------- per-cycle compare + observation ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy",         32'(busy),         32'(m_mode == M_LOAD || m_mode == M_SETTLE || m_mode == M_RUN));
            chk("done",         32'(done),         32'(m_mode == M_DONE));
            chk("s_ready",      32'(s_ready),      32'(m_mode == M_LOAD));
            chk("cpu_rst",      32'(cpu_rst),      32'(m_mode != M_RUN));
            chk("err_code",     32'(err_code),     32'(m_err));
            chk("words_loaded", 32'(words_loaded), 32'(m_words));
            chk("imem_we",      32'(imem_we),      32'(m_we));
            chk("imem_addr",    32'(imem_addr),    32'(m_addr));
            chk("imem_wdata",   32'(imem_wdata),   32'(m_wdata));
            if (imem_we === 1'b1) begin
                n_strobe++;
                mem[imem_addr] = imem_wdata;
                q_addr.push_back(int'(imem_addr));
            end
            if (cpu_rst === 1'b0) n_run++;
            if (busy === 1'b1 && s_ready === 1'b0 && cpu_rst === 1'b1) n_settle++;
        end
    end

    always @(posedge clk) begin
        #2;
        if (cpu_step) begin
            if (cpu_rst || prev_rst) cpu_pc = 8'd0;
            else                     cpu_pc = cpu_pc + 8'd1;
            cpu_instr = mem[cpu_pc];
        end else begin
            cpu_pc    = hold_pc;
            cpu_instr = hold_instr;
        end
        prev_rst = cpu_rst;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input int len);
        load_len = 9'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        s_valid = 1'b1;
        s_data  = b;
        tick();
        s_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int ns;
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        @(posedge clk);
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_err",     32'(err_code), 32'd0);
        chk("rst_words",   32'(words_loaded), 32'd0);
        reset = 1'b0;
        tick();

        // 1: back-to-back load of 4 bytes, halt at pc 3
        cpu_step = 1'b1; n_strobe = 0; n_settle = 0; n_run = 0; q_addr.delete();
        do_start(4);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'hF0, 0);
        wait_idle(50, "t1_timeout");
        chk("t1_done",    32'(done), 32'd1);
        chk("t1_err",     32'(err_code), 32'd0);
        chk("t1_words",   32'(words_loaded), 32'd4);
        chk("t1_strobes", 32'(n_strobe), 32'd4);
        chk("t1_settle",  32'(n_settle), 32'd2);
        chk("t1_runcyc",  32'(n_run), 32'd4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++) chk("t1_addr", 32'(q_addr[i]), 32'(i));

        pulse_abort_inline: begin
            abort = 1'b1; tick(); abort = 1'b0;
        end
        chk("abort_words", 32'(words_loaded), 32'd0);

        // 2: bad lengths
        cpu_step = 1'b0; n_strobe = 0; n_run = 0;
        do_start(0);
        chk("t2_len0_err",  32'(err_code), 32'd1);
        chk("t2_len0_busy", 32'(busy), 32'd0);
        do_start(257);
        chk("t2_len257_err", 32'(err_code), 32'd1);
        repeat (3) tick();
        chk("t2_strobes", 32'(n_strobe), 32'd0);
        chk("t2_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t2_runcyc",  32'(n_run), 32'd0);

        // 3: gappy load of 3 bytes
        cpu_step = 1'b1; n_strobe = 0; q_addr.delete();
        do_start(3);
        send(8'h01, 1); send(8'h02, 1); send(8'hF3, 1);
        wait_idle(50, "t3_timeout");
        chk("t3_done",    32'(done), 32'd1);
        chk("t3_strobes", 32'(n_strobe), 32'd3);
        chk("t3_words",   32'(words_loaded), 32'd3);
        for (int i = 0; i < 3 && i < q_addr.size(); i++) chk("t3_addr", 32'(q_addr[i]), 32'(i));

        // 4: watchdog
        cpu_step = 1'b0; hold_pc = 8'd0; hold_instr = 8'h00; n_run = 0;
        do_start(2);
        send(8'h00, 0); send(8'h00, 0);
        wait_idle(1200, "t4_timeout");
        chk("t4_err",     32'(err_code), 32'd2);
        chk("t4_runcyc",  32'(n_run), 32'd1000);
        chk("t4_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t4_done",    32'(done), 32'd0);

        // 5a: pc overrun
        hold_pc = 8'd2; n_run = 0;
        do_start(2);
        send(8'h00, 0); send(8'h00, 0);
        wait_idle(50, "t5a_timeout");
        chk("t5a_err",    32'(err_code), 32'd3);
        chk("t5a_runcyc", 32'(n_run), 32'd1);

        // 5b: halt in the same cycle as overrun wins
        hold_instr = 8'hF0; n_run = 0;
        do_start(2);
        send(8'h00, 0); send(8'h00, 0);
        wait_idle(50, "t5b_timeout");
        chk("t5b_done", 32'(done), 32'd1);
        chk("t5b_err",  32'(err_code), 32'd0);

        // 6: abort mid-load with a dropped byte, then reset during RUN, then a clean run
        hold_pc = 8'd0; hold_instr = 8'h00; n_strobe = 0;
        do_start(5);
        send(8'h10, 0); send(8'h20, 0);
        s_valid = 1'b1; s_data = 8'h30; abort = 1'b1;
        tick();
        abort = 1'b0; s_valid = 1'b0;
        tick(); tick();
        chk("t6_abort_strobes", 32'(n_strobe), 32'd2);
        chk("t6_abort_busy",    32'(busy), 32'd0);
        chk("t6_abort_words",   32'(words_loaded), 32'd0);
        chk("t6_abort_cpu_rst", 32'(cpu_rst), 32'd1);

        do_start(5);
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0); send(8'hF0, 0);
        k = 0;
        while (cpu_rst && k < 20) begin tick(); k++; end
        chk("t6_run_reached", 32'(cpu_rst), 32'd0);
        repeat (3) tick();
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("t6_rst_busy",    32'(busy), 32'd0);
        chk("t6_rst_words",   32'(words_loaded), 32'd0);
        ns = n_strobe;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (4) tick();
        chk("t6_no_strobes", 32'(n_strobe), 32'(ns));
        chk("t6_idle_busy",  32'(busy), 32'd0);

        cpu_step = 1'b1;
        do_start(5);
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0); send(8'hF0, 0);
        wait_idle(50, "t6_timeout");
        chk("t6_done",  32'(done), 32'd1);
        chk("t6_words", 32'(words_loaded), 32'd5);
        chk("t6_err",   32'(err_code), 32'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
